// File: rtl/cpu_port_bridge.sv
// cpu_port_bridge: on-chip I/O port (data + DDR) and core/system bus bridge with RDY halt sequencing.
// Define PORT_SYNC_EN to pass pin inputs through a 2-flop synchronizer before port reads.
module cpu_port_bridge #(
    parameter int          PORT_WIDTH = 8,
    parameter logic [7:0]  PORT_MASK  = 8'hDF,
    parameter logic [15:0] PORT_BASE  = 16'h0000
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  r_w_cpu,
    input  logic [15:0]           address_cpu,
    inout  logic [7:0]            data_cpu,
    output logic                  r_w_bus,
    output logic [15:0]           address_bus,
    inout  logic [7:0]            data_bus,
    input  logic                  aec,
    input  logic                  _rdy_bus,
    output logic                  _rdy_cpu,
    inout  logic [PORT_WIDTH-1:0] pio
);
    localparam logic [7:0] MASK = PORT_MASK & 8'((9'd1 << PORT_WIDTH) - 9'd1);

    typedef enum logic [1:0] {RUN, WAIT_RD, HALT} state_t;

    state_t     state_q, state_d;
    logic [7:0] ddr_q, ddr_d, out_q, out_d;
    logic [7:0] pin_raw, pin_val, port_rd;
    logic       hit, port_wr;

    assign hit     = address_cpu[15:1] == PORT_BASE[15:1];
    assign port_wr = hit & ~r_w_cpu;

    always_comb begin
        pin_raw = '0;
        pin_raw[PORT_WIDTH-1:0] = pio;
    end

`ifdef PORT_SYNC_EN
    logic [7:0] sync1_q, sync1_d, sync2_q, sync2_d;

    always_comb begin
        sync1_d = pin_raw & MASK;
        sync2_d = sync1_q;
    end

    always_ff @(negedge clock or posedge reset) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

    assign pin_val = sync2_q;
`else
    assign pin_val = pin_raw & MASK;
`endif

    // A pending halt waits for a read because the core cannot be stalled mid-write;
    // the pending state is frozen while video owns the bus.
    always_comb begin
        ddr_d   = (port_wr & address_cpu[0])  ? (data_cpu & MASK) : ddr_q;
        out_d   = (port_wr & ~address_cpu[0]) ? (data_cpu & MASK) : out_q;
        state_d = state_q;
        case (state_q)
            RUN:     state_d = _rdy_bus ? RUN : (r_w_cpu ? HALT : WAIT_RD);
            WAIT_RD: state_d = !aec ? WAIT_RD : _rdy_bus ? RUN : (r_w_cpu ? HALT : WAIT_RD);
            HALT:    state_d = _rdy_bus ? RUN : HALT;
            default: state_d = RUN;
        endcase
    end

    always_ff @(negedge clock or posedge reset) begin
        if (reset) begin
            ddr_q   <= '0;
            out_q   <= '0;
            state_q <= RUN;
        end else begin
            ddr_q   <= ddr_d;
            out_q   <= out_d;
            state_q <= state_d;
        end
    end

    assign port_rd     = address_cpu[0] ? ddr_q : (((ddr_q & out_q) | (~ddr_q & pin_val)) & MASK);
    assign data_cpu    = r_w_cpu ? ((hit & clock) ? port_rd : data_bus) : 8'bz;
    assign data_bus    = (~r_w_cpu & clock & ~hit) ? data_cpu : 8'bz;
    assign address_bus = aec ? address_cpu : 16'bz;
    assign r_w_bus     = aec ? r_w_cpu : 1'bz;
    assign _rdy_cpu    = aec & (state_q != HALT);

    for (genvar i = 0; i < PORT_WIDTH; i++) begin : g_pio
        assign pio[i] = ddr_q[i] ? out_q[i] : 1'bz;
    end
endmodule

// File: doc/cpu_port_bridge.md
CPU_PORT_BRIDGE -- requirements
Module: cpu_port_bridge

Interface
REQ-001 Parameter PORT_WIDTH, default 8, SHALL set the number of on-chip port bits, legal range 1..8.
REQ-002 Parameter PORT_MASK, default 8'hDF, SHALL select implemented bits; unimplemented bits read 0 and ignore writes.
REQ-003 Parameter PORT_BASE, default 16'h0000, SHALL set the data register address; the DDR sits at PORT_BASE+1.
REQ-004 clock  in  1  phi2 system clock; registers update on the falling edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 r_w_cpu  in  1  core read/write, 1 = read.
REQ-007 address_cpu  in  16  core address.
REQ-008 data_cpu  inout  8  core data bus.
REQ-009 r_w_bus  out  1  system read/write; Z while aec=0.
REQ-010 address_bus  out  16  system address; Z while aec=0.
REQ-011 data_bus  inout  8  system data bus.
REQ-012 aec  in  1  address enable control; 0 = bus owned by video.
REQ-013 _rdy_bus  in  1  system ready, active-low halt request.
REQ-014 _rdy_cpu  out  1  ready to core, 0 = stall.
REQ-015 pio  inout  PORT_WIDTH  port pins; each driven only when its DDR bit is 1.

Function
REQ-016 Port hit: address_cpu[15:1] == PORT_BASE[15:1]; bit 0 selects data (0) or DDR (1).
REQ-017 On a core write with clock=1 and no port hit, data_bus SHALL drive data_cpu and data_cpu SHALL be Z.
REQ-018 On a core write with a port hit, both data buses SHALL be Z, and the target register SHALL load data_cpu & PORT_MASK on the clock falling edge.
REQ-019 On a core read with a port hit and clock=1, data_cpu SHALL return the port value; data_bus SHALL be Z.
- Data: DDR bit 1 returns the output latch; DDR bit 0 returns the sampled pin value.
- DDR: returns the DDR register.
- Both are masked by PORT_MASK.
REQ-020 For all other reads, data_cpu SHALL follow data_bus.
REQ-021 The ready FSM SHALL have states RUN, WAIT_RD and HALT and SHALL advance on the clock falling edge.
- RUN -> HALT: _rdy_bus=0 and r_w_cpu=1.
- RUN -> WAIT_RD: _rdy_bus=0 and r_w_cpu=0; the halt is deferred because a write cannot be stalled.
- WAIT_RD -> HALT: on the first read cycle.
- WAIT_RD -> RUN: _rdy_bus returns to 1 before any read.
- HALT -> RUN: _rdy_bus=1.
REQ-022 _rdy_cpu SHALL be 0 in HALT and whenever aec=0; otherwise it SHALL be 1.
REQ-023 Two consecutive port writes in back-to-back cycles SHALL both take effect; no cycle is dropped.
REQ-024 An aec falling during WAIT_RD SHALL NOT alter the FSM state; the FSM resumes from that state when aec returns to 1.

Reset
REQ-025 Reset SHALL take effect immediately, independent of clock: DDR = 0, output latch = 0, FSM = RUN, pin samples = 0.
REQ-026 During reset all pio pins SHALL be Z, _rdy_cpu SHALL follow REQ-022 with state RUN, and data bus direction SHALL follow REQ-017..020.
REQ-027 Reset asserted mid-halt SHALL release the halt on the same cycle.

Configuration
REQ-028 Macro PORT_SYNC_EN defined: pin inputs SHALL pass through a 2-flop synchronizer on clock, so a pin change is visible to reads 2 falling edges later.
REQ-029 Macro PORT_SYNC_EN undefined: pin inputs SHALL be read combinationally with zero latency; all other behaviour is unchanged.

Verification
REQ-030 Reset, then write 8'hFF to DDR and 8'hA5 to data -> pio = 8'h85 (bit 5 Z), DDR readback = 8'hDF.
REQ-031 DDR = 8'h0F, drive pio[7:4] = 4'hC, read data -> 8'hC5 with PORT_SYNC_EN after 2 edges, immediately without it.
REQ-032 Write 8'h3C to 16'h1234 -> data_bus = 8'h3C, address_bus = 16'h1234, r_w_bus = 0; data_cpu Z.
REQ-033 _rdy_bus falls during a write, then a read follows -> _rdy_cpu stays 1 through the write and goes 0 on the read; _rdy_bus=1 -> _rdy_cpu = 1.
REQ-034 aec = 0 -> address_bus and r_w_bus Z, _rdy_cpu = 0; aec = 1 -> address_bus restored.
REQ-035 Assert reset while in HALT with DDR = 8'hFF -> _rdy_cpu = 1, all pio Z, DDR reads 8'h00.
